// File: rtl/fetch_queue.sv
// Decoupling FIFO between IF and ID. Each entry carries the fetch PC, the instruction
// word and the branch-prediction metadata through to EX unchanged.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PHT_W = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_pc,
    input  logic [31:0]      enq_instr,
    input  logic             enq_pred_taken,
    input  logic [PHT_W-1:0] enq_pht_idx,
    input  logic             enq_btb_hit,
    input  logic [31:0]      enq_btb_target,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      deq_pc,
    output logic [31:0]      deq_instr,
    output logic             deq_pred_taken,
    output logic [PHT_W-1:0] deq_pht_idx,
    output logic             deq_btb_hit,
    output logic [31:0]      deq_btb_target,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 32 + 32 + 1 + PHT_W + 1 + 32;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt_q;
    logic             enq_fire;
    logic             deq_fire;
    logic             empty;
    logic [ENT_W-1:0] head_ent;

    // Handshake: a side fires on the cycle where valid & ready are both high at the
    // posedge (enq additionally requires ~flush). While valid & ~ready the producer
    // must hold its payload stable. enq_ready depends only on registered count.
    assign empty     = (cnt_q == '0);
    assign enq_ready = (cnt_q != CNT_W'(DEPTH));
    assign deq_valid = ~empty & ~flush;
    assign enq_fire  = enq_valid & enq_ready & ~flush;
    assign deq_fire  = deq_valid & deq_ready;
    assign count     = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            cnt_q <= '0;
        end else begin
            if (enq_fire) begin
                tail <= (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;
            end
            if (deq_fire) begin
                head <= (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
            end
            if (enq_fire && !deq_fire) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (deq_fire && !enq_fire) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Storage is never cleared; an empty queue masks the head fields to zero instead.
    always_ff @(posedge clk) begin
        if (!rst && enq_fire) begin
            mem[tail] <= {enq_pc, enq_instr, enq_pred_taken, enq_pht_idx,
                          enq_btb_hit, enq_btb_target};
        end
    end

    assign head_ent = empty ? '0 : mem[head];
    assign {deq_pc, deq_instr, deq_pred_taken, deq_pht_idx,
            deq_btb_hit, deq_btb_target} = head_ent;

endmodule
